// File: rtl/soc_ctrl_rst_seq.sv
// Per-domain reset / clock-enable sequencer for the delay generator.
// Gates the clock, pulses reset, settles, then ungates; reports busy/done.
module soc_ctrl_rst_seq #(
   parameter int GATE_CYCLES   = 4,
   parameter int RST_CYCLES    = 16,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic ref_clk_i,
   input  logic glb_arst_ni,
   input  logic rst_req_i,
   input  logic clk_en_req_i,
   output logic arst_no,
   output logic clk_en_o,
   output logic busy_o,
   output logic done_o
);

   localparam int MAX_GR  = (GATE_CYCLES > RST_CYCLES) ? GATE_CYCLES : RST_CYCLES;
   localparam int MAX_ALL = (MAX_GR > SETTLE_CYCLES) ? MAX_GR : SETTLE_CYCLES;
   localparam int CNT_W   = (MAX_ALL < 1) ? 1 : $clog2(MAX_ALL + 1);

   localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      GATE,
      HOLD,
      SETTLE
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic             arst_d, clk_en_d, busy_d, done_d;
   logic             cnt_last;
   logic             req_any;

   assign cnt_last = (cnt_q == '0);
   assign req_any  = pend_q | rst_req_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q - 1'b1;
      pend_d  = pend_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            pend_d = 1'b0;
            cnt_d  = cnt_q;
            if (rst_req_i) begin
               state_d = GATE;
               cnt_d   = GATE_LD;
            end
         end
         GATE: begin
            pend_d = req_any;
            if (cnt_last) begin
               state_d = HOLD;
               cnt_d   = RST_LD;
            end
         end
         HOLD: begin
            pend_d = req_any;
            if (cnt_last) begin
               state_d = SETTLE;
               cnt_d   = SETTLE_LD;
            end
         end
         SETTLE: begin
            pend_d = req_any;
            if (cnt_last) begin
               // a request on the exit edge itself still earns one more pass
               done_d  = 1'b1;
               pend_d  = 1'b0;
               cnt_d   = GATE_LD;
               state_d = req_any ? GATE : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = cnt_q;
         end
      endcase
      arst_d   = (state_d != HOLD);
      busy_d   = (state_d != IDLE);
      clk_en_d = (state_d == IDLE) & clk_en_req_i;
   end

   always_ff @(posedge ref_clk_i or negedge glb_arst_ni) begin
      if (!glb_arst_ni) begin
         state_q  <= HOLD;
         cnt_q    <= RST_LD;
         pend_q   <= 1'b0;
         arst_no  <= 1'b0;
         clk_en_o <= 1'b0;
         busy_o   <= 1'b1;
         done_o   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         arst_no  <= arst_d;
         clk_en_o <= clk_en_d;
         busy_o   <= busy_d;
         done_o   <= done_d;
      end
   end

endmodule

// File: tb/tb_soc_ctrl_rst_seq.sv
// Bench for soc_ctrl_rst_seq: default and minimal-parameter instances
// checked each cycle against a sequence-position reference model.
module tb_soc_ctrl_rst_seq;

   logic       clk;
   logic       glb_arst_ni;
   logic       rst_req;
   logic       clk_en_req;
   logic [1:0] arst_w, clk_en_w, busy_w, done_w;

   int n_chk;
   int n_err;

   int g_p[2] = '{4, 1};
   int r_p[2] = '{16, 1};
   int s_p[2] = '{4, 1};

   bit act[2];
   int pos[2];
   bit pnd[2];
   bit done_e[2];
   bit clk_e[2];

   soc_ctrl_rst_seq u_dut0 (
      .ref_clk_i    (clk),
      .glb_arst_ni  (glb_arst_ni),
      .rst_req_i    (rst_req),
      .clk_en_req_i (clk_en_req),
      .arst_no      (arst_w[0]),
      .clk_en_o     (clk_en_w[0]),
      .busy_o       (busy_w[0]),
      .done_o       (done_w[0])
   );

   soc_ctrl_rst_seq #(
      .GATE_CYCLES   (1),
      .RST_CYCLES    (1),
      .SETTLE_CYCLES (1)
   ) u_dut1 (
      .ref_clk_i    (clk),
      .glb_arst_ni  (glb_arst_ni),
      .rst_req_i    (rst_req),
      .clk_en_req_i (clk_en_req),
      .arst_no      (arst_w[1]),
      .clk_en_o     (clk_en_w[1]),
      .busy_o       (busy_w[1]),
      .done_o       (done_w[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         act[k]    = 1'b1;
         pos[k]    = g_p[k];
         pnd[k]    = 1'b0;
         done_e[k] = 1'b0;
         clk_e[k]  = 1'b0;
      end
   endtask

   task automatic model_edge(input bit req, input bit en);
      for (int k = 0; k < 2; k++) begin
         done_e[k] = 1'b0;
         if (!act[k]) begin
            if (req) begin
               act[k] = 1'b1;
               pos[k] = 0;
            end
         end else begin
            pnd[k] = pnd[k] | req;
            pos[k] = pos[k] + 1;
            if (pos[k] == g_p[k] + r_p[k] + s_p[k]) begin
               done_e[k] = 1'b1;
               if (pnd[k]) begin
                  pos[k] = 0;
                  pnd[k] = 1'b0;
               end else begin
                  act[k] = 1'b0;
               end
            end
         end
         clk_e[k] = act[k] ? 1'b0 : en;
      end
   endtask

   task automatic check_all(input string ph);
      bit in_hold;
      for (int k = 0; k < 2; k++) begin
         in_hold = act[k] && pos[k] >= g_p[k] && pos[k] < g_p[k] + r_p[k];
         chk($sformatf("%s.d%0d.arst", ph, k), int'(arst_w[k]), int'(!in_hold));
         chk($sformatf("%s.d%0d.clk_en", ph, k), int'(clk_en_w[k]), int'(clk_e[k]));
         chk($sformatf("%s.d%0d.busy", ph, k), int'(busy_w[k]), int'(act[k]));
         chk($sformatf("%s.d%0d.done", ph, k), int'(done_w[k]), int'(done_e[k]));
         chk($sformatf("%s.d%0d.inv", ph, k), int'(clk_en_w[k] & ~arst_w[k]), 0);
      end
   endtask

   // called right after a falling edge; returns right after the next one
   task automatic step(input bit r, input bit e);
      rst_req    = r;
      clk_en_req = e;
      @(posedge clk);
      model_edge(r, e);
      #1;
      check_all("run");
      @(negedge clk);
   endtask

   task automatic glb_pulse();
      glb_arst_ni = 1'b0;
      #1;
      model_reset();
      check_all("arst");
      #1 glb_arst_ni = 1'b1;
      #1;
   endtask

   initial begin
      n_chk       = 0;
      n_err       = 0;
      rst_req     = 1'b0;
      clk_en_req  = 1'b1;
      glb_arst_ni = 1'b1;
      #1 glb_arst_ni = 1'b0;
      #1;
      model_reset();
      check_all("por");
      @(negedge clk);
      #1 glb_arst_ni = 1'b1;

      repeat (24) step(1'b0, 1'b1);

      step(1'b1, 1'b1);
      repeat (30) step(1'b0, 1'b1);

      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);

      step(1'b1, 1'b1);
      repeat (9) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      repeat (50) step(1'b0, 1'b1);

      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      repeat (6) step(1'b0, 1'b0);
      repeat (40) step(1'b0, 1'b1);

      step(1'b1, 1'b1);
      repeat (11) step(1'b0, 1'b1);
      glb_pulse();
      repeat (30) step(1'b0, 1'b1);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 249) == 0) begin
            glb_pulse();
         end else begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
         end
      end

      repeat (60) step(1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
